// File: rtl/multicycle_stage_sequencer_if.sv
// rtl/multicycle_stage_sequencer_if.sv - memory handshake, datapath strobe and status bundle for the stage sequencer
interface multicycle_stage_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      i_mem_di;
  logic             i_mem_ack;
  logic             d_mem_ack;
  logic             br_taken;
  logic             trap_clr;
  logic             i_mem_req;
  logic             d_mem_req;
  logic             d_mem_wen;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             alu_reg_we;
  logic             rf_we;
  logic [2:0]       stage;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  i_mem_di, i_mem_ack, d_mem_ack, br_taken, trap_clr,
    output i_mem_req, d_mem_req, d_mem_wen, ir_we, pc_we, pc_sel,
           alu_reg_we, rf_we, stage, trap, trap_cause, instret
  );

  modport slave (
    output i_mem_di, i_mem_ack, d_mem_ack, br_taken, trap_clr,
    input  i_mem_req, d_mem_req, d_mem_wen, ir_we, pc_we, pc_sel,
           alu_reg_we, rf_we, stage, trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_stage_sequencer.sv
// rtl/multicycle_stage_sequencer.sv - multicycle IF/ID/EX/MEM/WB sequencer with bounded memory waits and trap state
module multicycle_stage_sequencer #(
  parameter bit          SKIP_ID = 1'b1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  multicycle_stage_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    ST_IF = 3'b000, ST_ID = 3'b001, ST_EX = 3'b010,
    ST_MEM = 3'b011, ST_WB = 3'b100, ST_TRAP = 3'b101
  } stage_e;

  typedef enum logic [3:0] {
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_R, CL_I,
    CL_LOAD, CL_STORE, CL_BRANCH, CL_ILLEGAL
  } class_e;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  stage_e           state_q, state_d;
  class_e           class_q, class_d, fetch_class;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             waiting;
  logic             i_mem_req, d_mem_req, d_mem_wen, ir_we, pc_we, pc_sel, alu_reg_we, rf_we;
  logic             unused_di;

  function automatic class_e decode_class(input logic [6:0] opcode);
    class_e cls;
    case (opcode)
      7'b0110111: cls = CL_LUI;
      7'b0010111: cls = CL_AUIPC;
      7'b1101111: cls = CL_JAL;
      7'b1100111: cls = CL_JALR;
      7'b0110011: cls = CL_R;
      7'b0010011: cls = CL_I;
      7'b0000011: cls = CL_LOAD;
      7'b0100011: cls = CL_STORE;
      7'b1100011: cls = CL_BRANCH;
      default:    cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Only the opcode field is ever looked at; the class is latched so later stages ignore the bus.
  assign fetch_class = decode_class(bus.i_mem_di[6:0]);
  assign unused_di   = ^bus.i_mem_di[31:7];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IF;
      class_q   <= CL_ILLEGAL;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    cause_d    = cause_q;
    instret_d  = instret_q;
    waiting    = 1'b0;
    i_mem_req  = 1'b0;
    d_mem_req  = 1'b0;
    d_mem_wen  = 1'b1;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    alu_reg_we = 1'b0;
    rf_we      = 1'b0;

    case (state_q)
      ST_IF: begin
        i_mem_req = 1'b1;
        if (bus.i_mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          class_d = fetch_class;
          case (fetch_class)
            CL_LUI:         state_d = SKIP_ID ? ST_WB : ST_ID;
            CL_AUIPC, CL_JAL: state_d = SKIP_ID ? ST_EX : ST_ID;
            default:        state_d = ST_ID;
          endcase
        end else if (wait_q == TIMEOUT_W) begin
          state_d = ST_TRAP;
          cause_d = 2'b10;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_ID: begin
        case (class_q)
          CL_ILLEGAL: begin
            state_d = ST_TRAP;
            cause_d = 2'b01;
          end
          CL_LUI:  state_d = ST_WB;
          default: state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        alu_reg_we = 1'b1;
        case (class_q)
          CL_BRANCH: begin
            pc_we   = bus.br_taken;
            pc_sel  = bus.br_taken;
            state_d = ST_IF;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        d_mem_req = 1'b1;
        d_mem_wen = (class_q != CL_STORE);
        if (bus.d_mem_ack) begin
          state_d = (class_q == CL_STORE) ? ST_IF : ST_WB;
        end else if (wait_q == TIMEOUT_W) begin
          state_d = ST_TRAP;
          cause_d = 2'b11;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = (class_q == CL_JAL) || (class_q == CL_JALR);
        pc_sel  = (class_q == CL_JAL) || (class_q == CL_JALR);
        state_d = ST_IF;
      end
      ST_TRAP: begin
        if (bus.trap_clr) begin
          state_d = ST_IF;
          cause_d = 2'b00;
        end
      end
      default: state_d = ST_IF;
    endcase

    // Any state change restarts the wait count, so entry into IF or MEM always starts at zero.
    wait_d = (state_d != state_q) ? 8'd0 : (waiting ? wait_q + 8'd1 : 8'd0);

    if ((state_d == ST_IF) && (state_q != ST_IF) && (state_q != ST_TRAP)) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  assign bus.i_mem_req  = i_mem_req;
  assign bus.d_mem_req  = d_mem_req;
  assign bus.d_mem_wen  = d_mem_wen;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.alu_reg_we = alu_reg_we;
  assign bus.rf_we      = rf_we;
  assign bus.stage      = state_q;
  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// tb/tb_multicycle_stage_sequencer.sv - scoreboard bench for multicycle_stage_sequencer
module tb_multicycle_stage_sequencer;
  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010,
                         S_MEM = 3'b011, S_WB = 3'b100, S_TRAP = 3'b101;

  localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h0000A183, SW = 32'h0020A023,
                          BEQ = 32'h00208063, LUI = 32'h123450B7, JAL = 32'h0000006F,
                          JALR = 32'h000080E7, AUIPC = 32'h00000097, ILL = 32'h0000007F;

  typedef struct packed {
    logic [2:0]  stage;
    logic        i_req;
    logic        d_req;
    logic        d_wen;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        alu_we;
    logic        rf_we;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] instret;
  } rec_t;

  logic clk;
  logic rst;

  multicycle_stage_sequencer_if #(.CNT_W(CNT_W)) bus_a ();
  multicycle_stage_sequencer_if #(.CNT_W(CNT_W)) bus_b ();

  multicycle_stage_sequencer #(.SKIP_ID(1'b1), .TIMEOUT(4), .CNT_W(CNT_W)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );
  multicycle_stage_sequencer #(.SKIP_ID(1'b0), .TIMEOUT(4), .CNT_W(CNT_W)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  rec_t  exp_a[$], exp_b[$];
  string tag_a[$], tag_b[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic rec_t B(input logic [2:0] st, input logic [31:0] ret);
    rec_t r;
    r = '0;
    r.stage   = st;
    r.d_wen   = 1'b1;
    r.instret = ret;
    case (st)
      S_IF:    r.i_req  = 1'b1;
      S_EX:    r.alu_we = 1'b1;
      S_MEM:   r.d_req  = 1'b1;
      S_WB:    r.rf_we  = 1'b1;
      S_TRAP:  r.trap   = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic rec_t fe(input logic [31:0] ret);
    rec_t r;
    r = B(S_IF, ret);
    r.ir_we = 1'b1;
    r.pc_we = 1'b1;
    return r;
  endfunction

  function automatic rec_t wpc(input rec_t r0);
    rec_t r;
    r = r0;
    r.pc_we  = 1'b1;
    r.pc_sel = 1'b1;
    return r;
  endfunction

  function automatic rec_t tr(input logic [1:0] cause, input logic [31:0] ret);
    rec_t r;
    r = B(S_TRAP, ret);
    r.cause = cause;
    return r;
  endfunction

  function automatic rec_t obs(input int d);
    rec_t r;
    if (d == 0)
      r = {bus_a.stage, bus_a.i_mem_req, bus_a.d_mem_req, bus_a.d_mem_wen, bus_a.ir_we,
           bus_a.pc_we, bus_a.pc_sel, bus_a.alu_reg_we, bus_a.rf_we, bus_a.trap,
           bus_a.trap_cause, bus_a.instret};
    else
      r = {bus_b.stage, bus_b.i_mem_req, bus_b.d_mem_req, bus_b.d_mem_wen, bus_b.ir_we,
           bus_b.pc_we, bus_b.pc_sel, bus_b.alu_reg_we, bus_b.rf_we, bus_b.trap,
           bus_b.trap_cause, bus_b.instret};
    return r;
  endfunction

  task automatic check(input rec_t got, input rec_t e, input string tag);
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d ireq=%b dreq=%b wen=%b ir=%b pc=%b sel=%b alu=%b rf=%b trap=%b cause=%0d ret=%0d | exp st=%0d ireq=%b dreq=%b wen=%b ir=%b pc=%b sel=%b alu=%b rf=%b trap=%b cause=%0d ret=%0d",
               tag, got.stage, got.i_req, got.d_req, got.d_wen, got.ir_we, got.pc_we, got.pc_sel,
               got.alu_we, got.rf_we, got.trap, got.cause, got.instret,
               e.stage, e.i_req, e.d_req, e.d_wen, e.ir_we, e.pc_we, e.pc_sel,
               e.alu_we, e.rf_we, e.trap, e.cause, e.instret);
    end
  endtask

  always @(negedge clk) begin
    if (exp_a.size() > 0) check(obs(0), exp_a.pop_front(), tag_a.pop_front());
    if (exp_b.size() > 0) check(obs(1), exp_b.pop_front(), tag_b.pop_front());
  end

  task automatic step(input int d, input logic ack_i, input logic [31:0] di, input logic ack_d,
                      input logic br, input logic clr, input rec_t e, input string tag);
    if (d == 0) begin
      bus_a.i_mem_ack = ack_i; bus_a.i_mem_di = di; bus_a.d_mem_ack = ack_d;
      bus_a.br_taken = br; bus_a.trap_clr = clr;
      exp_a.push_back(e); tag_a.push_back(tag);
    end else begin
      bus_b.i_mem_ack = ack_i; bus_b.i_mem_di = di; bus_b.d_mem_ack = ack_d;
      bus_b.br_taken = br; bus_b.trap_clr = clr;
      exp_b.push_back(e); tag_b.push_back(tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input rec_t e, input string tag);
    step(d, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, tag);
  endtask

  task automatic fetch(input int d, input logic [31:0] di, input logic [31:0] ret, input string tag);
    step(d, 1'b1, di, 1'b0, 1'b0, 1'b0, fe(ret), tag);
  endtask

  initial begin
    logic [31:0] ra;
    rec_t e;
    rst = 1'b1;
    bus_a.i_mem_ack = 1'b0; bus_a.i_mem_di = '0; bus_a.d_mem_ack = 1'b0;
    bus_a.br_taken = 1'b0; bus_a.trap_clr = 1'b0;
    bus_b.i_mem_ack = 1'b0; bus_b.i_mem_di = '0; bus_b.d_mem_ack = 1'b0;
    bus_b.br_taken = 1'b0; bus_b.trap_clr = 1'b0;
    @(posedge clk);
    #1;

    // SKIP_ID=0 instance: LUI and AUIPC both visit ID
    idle(1, B(S_IF, 0), "b_rst_state");
    rst = 1'b0;
    fetch(1, LUI, 0, "b_lui_if");
    idle(1, B(S_ID, 0), "b_lui_id");
    idle(1, B(S_WB, 0), "b_lui_wb");
    fetch(1, AUIPC, 1, "b_auipc_if");
    idle(1, B(S_ID, 1), "b_auipc_id");
    idle(1, B(S_EX, 1), "b_auipc_ex");
    idle(1, B(S_WB, 1), "b_auipc_wb");
    idle(1, B(S_IF, 2), "b_end_if");

    // SKIP_ID=1 instance
    rst = 1'b1;
    idle(0, B(S_IF, 0), "rst_state");
    rst = 1'b0;
    ra = 0;
    fetch(0, SW, ra, "sw_if");
    idle(0, B(S_ID, ra), "sw_id");
    idle(0, B(S_EX, ra), "sw_ex");
    e = B(S_MEM, ra); e.d_wen = 1'b0;
    idle(0, e, "sw_mem");
    rst = 1'b1;
    idle(0, B(S_IF, 0), "rst_mid_mem");
    rst = 1'b0;

    fetch(0, ADD, ra, "add_if");
    idle(0, B(S_ID, ra), "add_id");
    idle(0, B(S_EX, ra), "add_ex");
    idle(0, B(S_WB, ra), "add_wb");
    ra++;

    fetch(0, LW, ra, "lw_if");
    idle(0, B(S_ID, ra), "lw_id");
    idle(0, B(S_EX, ra), "lw_ex");
    for (int i = 0; i < 3; i++) idle(0, B(S_MEM, ra), "lw_mem_wait");
    step(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, B(S_MEM, ra), "lw_mem_ack");
    idle(0, B(S_WB, ra), "lw_wb");
    ra++;

    fetch(0, BEQ, ra, "beq_t_if");
    idle(0, B(S_ID, ra), "beq_t_id");
    step(0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, wpc(B(S_EX, ra)), "beq_t_ex");
    ra++;
    fetch(0, BEQ, ra, "beq_nt_if");
    idle(0, B(S_ID, ra), "beq_nt_id");
    idle(0, B(S_EX, ra), "beq_nt_ex");
    ra++;

    fetch(0, LUI, ra, "lui_if");
    idle(0, B(S_WB, ra), "lui_wb");
    ra++;

    fetch(0, JAL, ra, "jal_if");
    idle(0, B(S_EX, ra), "jal_ex");
    idle(0, wpc(B(S_WB, ra)), "jal_wb");
    ra++;

    fetch(0, JALR, ra, "jalr_if");
    idle(0, B(S_ID, ra), "jalr_id");
    idle(0, B(S_EX, ra), "jalr_ex");
    idle(0, wpc(B(S_WB, ra)), "jalr_wb");
    ra++;

    fetch(0, ILL, ra, "ill_if");
    idle(0, B(S_ID, ra), "ill_id");
    idle(0, tr(2'b01, ra), "ill_trap");
    step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, tr(2'b01, ra), "ill_trap_clr");

    // I-fetch timeout after five unacknowledged IF cycles; TRAP_CLR outside TRAP is ignored
    step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, B(S_IF, ra), "if_wait_clr_ignored");
    for (int i = 0; i < 3; i++) idle(0, B(S_IF, ra), "if_wait");
    idle(0, B(S_IF, ra), "if_timeout_cycle");
    step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, tr(2'b10, ra), "if_timeout_trap");

    // ack on the cycle the count reaches the limit wins
    for (int i = 0; i < 4; i++) idle(0, B(S_IF, ra), "if_wait_limit");
    fetch(0, ADD, ra, "if_ack_at_limit");
    idle(0, B(S_ID, ra), "limit_add_id");
    idle(0, B(S_EX, ra), "limit_add_ex");
    idle(0, B(S_WB, ra), "limit_add_wb");
    ra++;

    // D-mem timeout
    fetch(0, LW, ra, "lw_to_if");
    step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, B(S_ID, ra), "lw_to_id_clr_ignored");
    idle(0, B(S_EX, ra), "lw_to_ex");
    for (int i = 0; i < 4; i++) idle(0, B(S_MEM, ra), "mem_wait");
    idle(0, B(S_MEM, ra), "mem_timeout_cycle");
    idle(0, tr(2'b11, ra), "mem_timeout_trap");
    step(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, tr(2'b11, ra), "mem_trap_clr");
    idle(0, B(S_IF, ra), "after_trap_instret_kept");

    @(posedge clk);
    #1;
    n_tests++;
    if ((exp_a.size() != 0) || (exp_b.size() != 0)) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d/%0d pending, exp 0/0", exp_a.size(), exp_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
